// File: rtl/xnor_dot_ctrl_pkg.sv
// Shared widths and FSM encoding for the binary XNOR/popcount dot-product controller.
package xnor_dot_ctrl_pkg;

  parameter int unsigned WORD_W = 16;
  parameter int unsigned LEN_W  = 8;
  parameter int unsigned HAM_W  = LEN_W + 4;
  parameter int unsigned DOT_W  = LEN_W + 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/xnor_dot_ctrl_xor.sv
// Existing 16-bit bitwise XOR datapath; a set output bit marks a sign mismatch.
module XorX16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xnor_dot_ctrl.sv
// Binary dot-product controller: accumulates per-word mismatch counts over a job of len
// word pairs, then presents hamming and the signed dot product until consumed.
module xnor_dot_ctrl
  import xnor_dot_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W = xnor_dot_ctrl_pkg::WORD_W,
  parameter int unsigned LEN_W  = xnor_dot_ctrl_pkg::LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 abort,
  input  logic [WORD_W-1:0]    a_data,
  input  logic [WORD_W-1:0]    b_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [LEN_W+3:0]     hamming,
  output logic [LEN_W+4:0]     dot,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy
);

  localparam int unsigned HamW = LEN_W + 4;
  localparam int unsigned DotW = LEN_W + 5;
  localparam int unsigned PopW = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [HamW-1:0]   ham_q, ham_d;

  logic [WORD_W-1:0] diff;
  logic [PopW-1:0]   pop;
  logic              beat;

  XorX16 u_xor (
    .a (a_data),
    .b (b_data),
    .y (diff)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      pop = pop + PopW'(diff[i]);
    end
  end

  assign in_ready     = (state_q == StRun);
  assign result_valid = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign beat         = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ham_d   = ham_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len;
          cnt_d   = len;
          ham_d   = '0;
          state_d = (len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          len_d   = '0;
          ham_d   = '0;
          state_d = StIdle;
        end else if (beat) begin
          ham_d = ham_q + HamW'(pop);
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = StDone;
        end
      end
      StDone: begin
        // Abort wins over result_ready so a cancelled job never leaves a stale result.
        if (abort) begin
          len_d   = '0;
          ham_d   = '0;
          state_d = StIdle;
        end else if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      ham_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ham_q   <= ham_d;
    end
  end

  // Each word contributes WORD_W agreements minus 2 per mismatch; the sum fits DotW exactly.
  logic [DotW-1:0] total_bits;
  assign total_bits = DotW'(len_q) * DotW'(WORD_W);
  assign hamming    = ham_q;
  assign dot        = total_bits - {ham_q, 1'b0};

endmodule

// File: doc/xnor_dot_ctrl.md
XNOR_DOT_CTRL -- requirements
Module: xnor_dot_ctrl

Interface
REQ-001 Parameter WORD_W, 16, operand word width in bits.
REQ-002 Parameter LEN_W, 8, width of the vector-length field; maximum vector length is 2^LEN_W-1 words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin a dot-product job; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of words in the job; sampled with start.
REQ-007 abort  input  1  synchronous job cancel.
REQ-008 a_data  input  WORD_W  activation word (binary, bit 1 = +1, bit 0 = -1).
REQ-009 b_data  input  WORD_W  weight word, same encoding.
REQ-010 in_valid  input  1  a_data/b_data valid.
REQ-011 in_ready  output  1  controller accepts a word pair this cycle.
REQ-012 hamming  output  LEN_W+4  accumulated mismatch count.
REQ-013 dot  output  LEN_W+5  signed dot product, two's complement.
REQ-014 result_valid  output  1  hamming/dot final and stable.
REQ-015 result_ready  input  1  consumer takes the result.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE: start=1 with len!=0 SHALL latch len into a remaining-word counter, clear the accumulator and enter RUN; start=1 with len=0 SHALL enter DONE with hamming=0 and dot=0.
REQ-019 RUN: in_ready SHALL be 1; in_ready SHALL be 0 in IDLE and DONE.
REQ-020 A beat is accepted when in_valid && in_ready; on each beat, popcount(a_data XOR b_data) SHALL be added to the accumulator and the counter decremented, with zero-cycle latency through the XOR and popcount.
REQ-021 Cycles with in_valid=0 in RUN SHALL leave the accumulator and counter unchanged; gaps of any length SHALL be allowed.
REQ-022 The accepted beat that decrements the counter to 0 SHALL cause entry to DONE on the next edge; result_valid SHALL be 1 exactly while in DONE.
REQ-023 In DONE, dot SHALL equal WORD_W*len_latched - 2*hamming, computed at full width with no overflow; for the defaults the range is -4080..+4080.
REQ-024 hamming and dot SHALL hold stable while result_valid=1 && result_ready=0.
REQ-025 DONE with result_ready=1 SHALL return to IDLE on the next edge; the outputs SHALL keep their last values until the next start.
REQ-026 abort=1 in RUN or DONE SHALL enter IDLE on the next edge, discard the job and clear hamming and dot to 0; abort SHALL take priority over a simultaneous beat, result_ready or start.
REQ-027 start asserted in RUN or DONE SHALL be ignored; no queueing.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and drive in_ready=0, result_valid=0, busy=0, hamming=0 and dot=0, including mid-job.
REQ-029 After rst_n deasserts, the first accepted start SHALL behave identically to a start from power-up.

Structure
REQ-030 A shared package SHALL hold WORD_W, LEN_W, the derived widths HAM_W=LEN_W+4 and DOT_W=LEN_W+5, and the FSM state encoding.
REQ-031 The XOR stage SHALL instantiate the existing 16-bit XorX16 datapath as the single sub-module; popcount and the accumulator SHALL be local logic.

Verification
REQ-032 len=1, beat a=0x0110, b=0x0047 -> hamming=6, dot=4, with result_valid rising on the cycle after the beat.
REQ-033 len=2, beats (0x0110,0x0047) then (0x01A4,0x0491), with 3 idle in_valid cycles between them -> hamming=12, dot=8.
REQ-034 len=255, every beat a=0xFFFF, b=0x0000 -> hamming=4080, dot=-4080; len=3 with all-zero operands -> hamming=0, dot=48.
REQ-035 len=0 start -> DONE on the next cycle with hamming=0 and dot=0; hold result_ready=0 for 5 cycles -> outputs stable; result_ready=1 -> IDLE.
REQ-036 abort asserted on the same cycle as the 2nd beat of a len=4 job -> IDLE next cycle with hamming=0, no result_valid pulse; a following len=1 job is correct.
REQ-037 rst_n pulsed low mid-RUN, asynchronous to clk -> outputs zero immediately; start ignored during reset; a following job is correct.
